mesh: RTL and testbench
=======================

MESH -- requirements
Module: mesh

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the PE count; N SHALL be a perfect square R*R with R >= 2.
REQ-002 The block SHALL have parameter SORT_CYCLES, default 21, giving the cycle of the memory write; SORT_CYCLES SHALL equal R*(2*ceil(log2 R)+1)+1.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 4, giving the address width (log2 N); packet width = ADDR_WIDTH+DATA_WIDTH.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have no other ports; results SHALL be observable hierarchically at GEN[k].GENIF.PE.nanci_init.memory (DATA_WIDTH bits, k = 0..N-1).

Function
REQ-008 PEs SHALL form an R x R mesh; PE k SHALL sit at row k/R, column k%R for even rows and R-1-k%R for odd rows (snake order).
REQ-009 Each PE SHALL hold one packet {addr, data} and one memory register.
REQ-010 A step counter SHALL reset to 0, increment each clock, and saturate at SORT_CYCLES.
REQ-011 While counter s < SORT_CYCLES-1, one shearsort compare-exchange step SHALL run: phase p = s/R, t = s%R.
REQ-012 Even p: row phase; even rows sort ascending by addr left-to-right, odd rows descending.
REQ-013 Odd p: column phase; all columns sort ascending by addr top-to-bottom.
REQ-014 Within a phase, even t SHALL compare pairs (0,1),(2,3),...; odd t SHALL compare pairs (1,2),(3,4),...
REQ-015 A pair SHALL swap whole packets only if strictly out of order; equal addrs SHALL NOT swap.
REQ-016 At s == SORT_CYCLES-1, every PE k SHALL load memory <= its packet data; no packet moves this cycle.
REQ-017 At s == SORT_CYCLES the mesh SHALL idle: packets and memory held indefinitely.
REQ-018 Ending packet order SHALL be snake-order ascending, so PE k holds addr k when it writes.

Reset
REQ-019 On rst low, asynchronously: counter = 0; every memory = 0; PE k packet = {addr N-1-k, data k}.
REQ-020 Reset asserted mid-sort or after completion SHALL abort and restart the full sequence from step 0 after release.
REQ-021 With the defaults, PE k memory SHALL equal N-1-k from cycle SORT_CYCLES after reset release onward.

Configuration
REQ-022 With macro MESH_SORT_CHECK_EN defined, simulation SHALL $error once per PE whose packet addr != k at the write cycle; without it, no check logic SHALL be compiled and function SHALL be identical.

Verification
REQ-023 Defaults: release reset, run 100 cycles -> memory[k] = 15-k for all k = 0..15.
REQ-024 Write timing: memory stays 0 through clock 20 after release -> all values written on clock 21.
REQ-025 First row phase: after 4 steps -> row 0 addrs ascending, row 1 descending.
REQ-026 Reset pulse at cycle 10 -> memories reset to 0, then after 21 clocks memory[k] = 15-k.
REQ-027 Completion hold: run 200 cycles -> memories unchanged after clock 21, counter = 21.
REQ-028 MESH_SORT_CHECK_EN defined, default run -> zero $error messages.

Source files
------------

// File: rtl/mesh.sv
// Snake-order shearsort over an R x R mesh of PEs; each PE latches its sorted packet data at step SORT_CYCLES-1.
// Optional macro MESH_SORT_CHECK_EN adds a simulation check that each PE holds addr k at the write step.
module mesh_mem #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_dat
);
   logic [DATA_WIDTH-1:0] memory;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         memory <= '0;
      else if (i_wr)
         memory <= i_dat;
   end
endmodule

module mesh_pe #(
   parameter int K          = 0,
   parameter int N          = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_pkt_en,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_pkt_nxt,
   input  logic                             i_wr,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_pkt
);
   localparam int PW = ADDR_WIDTH + DATA_WIDTH;

   logic [PW-1:0] r_pkt;

   // Reset image is the fully reversed sequence: addr N-1-K, data K.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_pkt <= {ADDR_WIDTH'(N-1-K), DATA_WIDTH'(K)};
      else if (i_pkt_en)
         r_pkt <= i_pkt_nxt;
   end

   assign o_pkt = r_pkt;

   mesh_mem #(.DATA_WIDTH(DATA_WIDTH)) nanci_init (
      .clk   (clk),
      .rst   (rst),
      .i_wr  (i_wr),
      .i_dat (r_pkt[DATA_WIDTH-1:0])
   );

`ifdef MESH_SORT_CHECK_EN
   always @(posedge clk) begin
      if (rst && i_wr && (r_pkt[PW-1 -: ADDR_WIDTH] != ADDR_WIDTH'(K)))
         $error("mesh PE %0d holds addr %0d at write step", K, r_pkt[PW-1 -: ADDR_WIDTH]);
   end
`else
`endif
endmodule

module mesh #(
   parameter int N           = 16,
   parameter int SORT_CYCLES = 21,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic clk,
   input  logic rst
);
   function automatic int f_isqrt(input int n);
      int v;
      v = 0;
      while ((v + 1) * (v + 1) <= n)
         v++;
      return v;
   endfunction

   localparam int R  = f_isqrt(N);
   localparam int PW = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(SORT_CYCLES + 1);
   localparam logic [CW-1:0] LP_WR   = CW'(SORT_CYCLES - 1);
   localparam logic [CW-1:0] LP_DONE = CW'(SORT_CYCLES);

   // Grid (row, col) to PE index; odd rows run right-to-left.
   function automatic int f_idx(input int r, input int c);
      return r * R + (((r % 2) == 0) ? c : (R - 1 - c));
   endfunction

   logic [CW-1:0] r_step;
   logic [PW-1:0] w_pkt [N];
   logic [PW-1:0] w_nxt [N];
   logic          w_sort_en;
   logic          w_wr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_step <= '0;
      else if (r_step != LP_DONE)
         r_step <= r_step + 1'b1;
   end

   assign w_sort_en = (r_step < LP_WR);
   assign w_wr      = (r_step == LP_WR);

   always_comb begin
      int  v_p;
      int  v_t;
      int  v_a;
      int  v_b;
      logic v_swap;
      w_nxt  = w_pkt;
      v_p    = int'(r_step) / R;
      v_t    = int'(r_step) % R;
      v_a    = 0;
      v_b    = 0;
      v_swap = 1'b0;
      // Pairs within a step are disjoint, so reading only w_pkt is safe.
      for (int l = 0; l < R; l++) begin
         for (int i = 0; i < R - 1; i++) begin
            if ((i % 2) == (v_t % 2)) begin
               if ((v_p % 2) == 0) begin
                  v_a    = f_idx(l, i);
                  v_b    = f_idx(l, i + 1);
                  v_swap = ((l % 2) == 0) ?
                           (w_pkt[v_a][PW-1 -: ADDR_WIDTH] > w_pkt[v_b][PW-1 -: ADDR_WIDTH]) :
                           (w_pkt[v_a][PW-1 -: ADDR_WIDTH] < w_pkt[v_b][PW-1 -: ADDR_WIDTH]);
               end else begin
                  v_a    = f_idx(i, l);
                  v_b    = f_idx(i + 1, l);
                  v_swap = (w_pkt[v_a][PW-1 -: ADDR_WIDTH] > w_pkt[v_b][PW-1 -: ADDR_WIDTH]);
               end
               if (v_swap) begin
                  w_nxt[v_a] = w_pkt[v_b];
                  w_nxt[v_b] = w_pkt[v_a];
               end
            end
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : GEN
      if (R >= 2) begin : GENIF
         mesh_pe #(
            .K          (k),
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) PE (
            .clk       (clk),
            .rst       (rst),
            .i_pkt_en  (w_sort_en),
            .i_pkt_nxt (w_nxt[k]),
            .i_wr      (w_wr),
            .o_pkt     (w_pkt[k])
         );
      end
   end
endmodule

// File: tb/tb_mesh.sv
// Directed bench for mesh: reset image, first row phase, write timing, completion hold and reset abort.
module tb_mesh;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   logic [31:0] w_mem  [16];
   logic [3:0]  w_addr [16];
   logic [31:0] w_data [16];
   logic [4:0]  w_step;

   mesh dut (
      .clk (clk),
      .rst (rst)
   );

   for (genvar k = 0; k < 16; k++) begin : MON
      assign w_mem[k]  = dut.GEN[k].GENIF.PE.nanci_init.memory;
      assign w_addr[k] = dut.GEN[k].GENIF.PE.o_pkt[35:32];
      assign w_data[k] = dut.GEN[k].GENIF.PE.o_pkt[31:0];
   end
   assign w_step = dut.r_step;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_mem_all(input string tag, input bit sorted);
      for (int k = 0; k < 16; k++)
         chk($sformatf("%s_mem%0d", tag, k), w_mem[k], sorted ? 32'(15 - k) : 32'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b0;
      tick(2);

      chk("rst_step", 32'(w_step), 32'd0);
      chk_mem_all("rst", 1'b0);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("rst_addr%0d", k), 32'(w_addr[k]), 32'(15 - k));
         chk($sformatf("rst_data%0d", k), w_data[k], 32'(k));
      end

      rst = 1'b1;
      tick(4);
      // After the first row phase each row is sorted; rows still hold their original address bands.
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("row_addr%0d", k), 32'(w_addr[k]), 32'((3 - k / 4) * 4 + k % 4));
         chk($sformatf("row_data%0d", k), w_data[k], 32'(15 - ((3 - k / 4) * 4 + k % 4)));
      end

      tick(16);
      chk("c20_step", 32'(w_step), 32'd20);
      chk_mem_all("c20", 1'b0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("c20_addr%0d", k), 32'(w_addr[k]), 32'(k));

      tick(1);
      chk("c21_step", 32'(w_step), 32'd21);
      chk_mem_all("c21", 1'b1);

      tick(179);
      chk("c200_step", 32'(w_step), 32'd21);
      chk_mem_all("c200", 1'b1);
      for (int k = 0; k < 16; k++)
         chk($sformatf("c200_addr%0d", k), 32'(w_addr[k]), 32'(k));

      // Asynchronous reset after completion clears memories without a clock edge.
      rst = 1'b0;
      #1;
      chk("done_rst_step", 32'(w_step), 32'd0);
      chk_mem_all("done_rst", 1'b0);
      tick(1);
      rst = 1'b1;
      tick(10);
      chk("mid_step", 32'(w_step), 32'd10);

      rst = 1'b0;
      #1;
      chk("mid_rst_step", 32'(w_step), 32'd0);
      chk("mid_rst_addr0", 32'(w_addr[0]), 32'd15);
      tick(1);
      rst = 1'b1;
      tick(20);
      chk_mem_all("re20", 1'b0);
      tick(1);
      chk("re21_step", 32'(w_step), 32'd21);
      chk_mem_all("re21", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
